// File: rtl/fifo_serializer.sv
// Read-side consumer for the CDC FIFO: pops DATA_WIDTH-bit words and emits them
// LS slice first as OUT_WIDTH-bit slices on a valid/ready handshake.
//
//   state | meaning
//   IDLE  | no word held; pops when enabled and the FIFO is non-empty
//   SHIFT | word held; presenting slice slice_idx, reloads on the last transfer
module fifo_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int COUNT_BITS = 2
) (
    input  logic                  read_clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [15:0]           word_count
);

    localparam int SLICES = DATA_WIDTH / OUT_WIDTH;
    localparam logic [COUNT_BITS-1:0] LAST_IDX = COUNT_BITS'(SLICES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [COUNT_BITS-1:0]   idx_q, idx_d;
    logic [15:0]             count_q, count_d;
    logic                    pop;
    logic                    is_last;

    assign is_last = (idx_q == LAST_IDX);

    always_ff @(posedge read_clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        count_d = count_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    pop = 1'b1;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    if (!is_last) begin
                        shift_d = shift_q >> OUT_WIDTH;
                        idx_d   = idx_q + COUNT_BITS'(1);
                    end else if (enable && !fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop always loads a fresh word, whether from IDLE or as a gapless reload.
        if (pop) begin
            shift_d = fifo_q;
            idx_d   = '0;
            count_d = count_q + 16'd1;
            state_d = SHIFT;
        end
    end

    assign fifo_read_enable = pop & reset;
    assign busy             = (state_q == SHIFT);
    assign out_valid        = busy;
    assign out_data         = shift_q[OUT_WIDTH-1:0];
    assign out_last         = busy & is_last;
    assign word_count       = count_q;

endmodule
